// File: rtl/psram_apb_qpi_ctrl_pkg.sv
// rtl/psram_apb_qpi_ctrl_pkg.sv - shared opcodes, FSM states and strobe decode for the QPI PSRAM controller
package psram_apb_qpi_ctrl_pkg;

    localparam logic [7:0] CMD_WR_DEF    = 8'h38;
    localparam logic [7:0] CMD_RD_DEF    = 8'hEB;
    localparam int         DUMMY_CYC_DEF = 7;
    localparam int         ADDR_W        = 24;
    // Wide enough for the longest phase (8 sck periods).
    localparam int         CNT_W         = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_WDATA,
        S_RDATA,
        S_DONE
    } state_t;

    // ok: strobe is a contiguous non-zero run; lo: lowest set lane; n: lanes set.
    typedef struct packed {
        logic       ok;
        logic [1:0] lo;
        logic [2:0] n;
    } strb_info_t;

    function automatic strb_info_t decode_strb(input logic [3:0] s);
        strb_info_t r;
        r = '0;
        case (s)
            4'b0001: r = {1'b1, 2'd0, 3'd1};
            4'b0010: r = {1'b1, 2'd1, 3'd1};
            4'b0100: r = {1'b1, 2'd2, 3'd1};
            4'b1000: r = {1'b1, 2'd3, 3'd1};
            4'b0011: r = {1'b1, 2'd0, 3'd2};
            4'b0110: r = {1'b1, 2'd1, 3'd2};
            4'b1100: r = {1'b1, 2'd2, 3'd2};
            4'b0111: r = {1'b1, 2'd0, 3'd3};
            4'b1110: r = {1'b1, 2'd1, 3'd3};
            4'b1111: r = {1'b1, 2'd0, 3'd4};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Bus words are little-endian while the wire order is first byte in the top bits.
    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/psram_apb_qpi_ctrl_shifter.sv
// rtl/psram_apb_qpi_ctrl_shifter.sv - sck divider, phase period counter and shift-out/shift-in register
module psram_apb_qpi_ctrl_shifter
    import psram_apb_qpi_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [31:0]      i_data,
    input  logic             i_wide,
    input  logic [CNT_W-1:0] i_count,
    input  logic [3:0]       i_din,
    output logic             o_sck,
    output logic [3:0]       o_dout,
    output logic [31:0]      o_rdata,
    output logic             o_last,
    output logic             o_idle
);

    logic             r_sck;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wide;
    logic [31:0]      r_sr;
    logic [31:0]      r_rd;

    // A load always lands on a sck-low edge; after that each period is a LOW clock then a HIGH clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sck  <= 1'b0;
            r_cnt  <= '0;
            r_wide <= 1'b0;
            r_sr   <= '0;
            r_rd   <= '0;
        end else if (i_load) begin
            r_sck  <= 1'b0;
            r_cnt  <= i_count;
            r_wide <= i_wide;
            r_sr   <= i_data;
        end else if (r_cnt != '0) begin
            if (!r_sck) begin
                r_sck <= 1'b1;
                r_rd  <= {r_rd[27:0], i_din};
            end else begin
                r_sck <= 1'b0;
                r_cnt <= r_cnt - 1'b1;
                r_sr  <= r_wide ? {r_sr[27:0], 4'h0} : {r_sr[30:0], 1'b0};
            end
        end
    end

    assign o_sck   = r_sck;
    assign o_dout  = r_wide ? r_sr[31:28] : {3'b000, r_sr[31]};
    assign o_rdata = r_rd;
    // HIGH clock of the final period: the next edge is the phase's closing low edge.
    assign o_last  = r_sck && (r_cnt == CNT_W'(1));
    assign o_idle  = (r_cnt == '0);

endmodule

// File: rtl/psram_apb_qpi_ctrl.sv
// rtl/psram_apb_qpi_ctrl.sv - APB slave turning 32-bit accesses into QPI PSRAM transactions
module psram_apb_qpi_ctrl
    import psram_apb_qpi_ctrl_pkg::*;
#(
    parameter logic [7:0] CMD_WR    = CMD_WR_DEF,
    parameter logic [7:0] CMD_RD    = CMD_RD_DEF,
    parameter int         DUMMY_CYC = DUMMY_CYC_DEF
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_psel,
    input  logic        i_penable,
    input  logic        i_pwrite,
    input  logic [31:0] i_paddr,
    input  logic [31:0] i_pwdata,
    input  logic [3:0]  i_pstrb,
    output logic        o_pready,
    output logic [31:0] o_prdata,
    output logic        o_pslverr,
    output logic        o_psram_sck,
    output logic        o_psram_ce_n,
    output logic [3:0]  o_psram_dio_o,
    output logic [3:0]  o_psram_dio_oe,
    input  logic [3:0]  i_psram_dio_i
);

    state_t             r_state;
    logic               r_write;
    logic               r_bad;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [CNT_W-1:0]   r_wcnt;
    logic               r_ce_n;
    logic [3:0]         r_oe;
    logic               r_pready;
    logic               r_pslverr;
    logic [31:0]        r_prdata;

    strb_info_t         w_strb;
    logic               w_req;
    logic               w_bad_now;
    logic               w_load;
    logic [31:0]        w_ld_data;
    logic               w_ld_wide;
    logic [CNT_W-1:0]   w_ld_count;
    logic               w_last;
    logic               w_idle;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_strb    = decode_strb(i_pstrb);
    assign w_req     = i_psel && i_penable && !r_pready;
    assign w_bad_now = i_pwrite && !w_strb.ok;
    assign w_unused  = ^i_paddr[31:ADDR_W];

    // Phase loads happen on the same edge the FSM changes phase, so they are decoded combinationally.
    always_comb begin
        w_load     = 1'b0;
        w_ld_data  = '0;
        w_ld_wide  = 1'b0;
        w_ld_count = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_bad_now) begin
                    w_load     = 1'b1;
                    w_ld_data  = {(i_pwrite ? CMD_WR : CMD_RD), 24'h0};
                    w_ld_count = CNT_W'(8);
                end
            end
            S_CMD: begin
                if (w_last) begin
                    w_load     = 1'b1;
                    w_ld_data  = {r_addr, 8'h00};
                    w_ld_wide  = 1'b1;
                    w_ld_count = CNT_W'(6);
                end
            end
            S_ADDR: begin
                if (w_last) begin
                    w_load     = 1'b1;
                    w_ld_wide  = 1'b1;
                    w_ld_data  = r_write ? r_wdata : 32'h0;
                    w_ld_count = r_write ? r_wcnt : CNT_W'(DUMMY_CYC);
                end
            end
            S_DUMMY: begin
                if (w_last) begin
                    w_load     = 1'b1;
                    w_ld_wide  = 1'b1;
                    w_ld_count = CNT_W'(8);
                end
            end
            S_WDATA, S_RDATA: begin
                // Closing low edge: park sck low with dio_o cleared.
                w_load = w_last;
            end
            default: ;
        endcase
    end

    // Transaction sequencer; ce_n, oe and the APB response are all registered here.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_write   <= 1'b0;
            r_bad     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wcnt    <= '0;
            r_ce_n    <= 1'b1;
            r_oe      <= 4'b0000;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_write <= i_pwrite;
                        if (w_bad_now) begin
                            r_bad   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_bad   <= 1'b0;
                            r_ce_n  <= 1'b0;
                            r_oe    <= 4'b0001;
                            r_addr  <= {i_paddr[ADDR_W-1:2], (i_pwrite ? w_strb.lo : 2'b00)};
                            r_wdata <= bswap32(i_pwdata >> {w_strb.lo, 3'b000});
                            r_wcnt  <= {w_strb.n, 1'b0};
                            r_state <= S_CMD;
                        end
                    end
                end
                S_CMD: begin
                    if (w_last) begin
                        r_oe    <= 4'b1111;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_last) begin
                        if (r_write) begin
                            r_state <= S_WDATA;
                        end else begin
                            r_oe    <= 4'b0000;
                            r_state <= S_DUMMY;
                        end
                    end
                end
                S_DUMMY: begin
                    if (w_last) begin
                        r_state <= S_RDATA;
                    end
                end
                S_WDATA, S_RDATA: begin
                    if (w_last) begin
                        r_oe <= 4'b0000;
                    end else if (w_idle) begin
                        r_ce_n  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // First DONE clock keeps ce_n high before the pulse so the device always sees >=2 idle clocks.
                    if (!r_pready) begin
                        r_pready  <= 1'b1;
                        r_pslverr <= r_bad;
                        r_prdata  <= r_write ? 32'h0 : bswap32(w_rdata);
                    end else begin
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                        r_prdata  <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    psram_apb_qpi_ctrl_shifter u_shifter (
        .i_clk   (i_clock),
        .i_rst_n (i_reset_n),
        .i_load  (w_load),
        .i_data  (w_ld_data),
        .i_wide  (w_ld_wide),
        .i_count (w_ld_count),
        .i_din   (i_psram_dio_i),
        .o_sck   (o_psram_sck),
        .o_dout  (o_psram_dio_o),
        .o_rdata (w_rdata),
        .o_last  (w_last),
        .o_idle  (w_idle)
    );

    assign o_psram_ce_n   = r_ce_n;
    assign o_psram_dio_oe = r_oe;
    assign o_pready       = r_pready;
    assign o_pslverr      = r_pslverr;
    assign o_prdata       = r_prdata;

endmodule

// File: tb/tb_psram_apb_qpi_ctrl.sv
// tb/tb_psram_apb_qpi_ctrl.sv - self-checking bench with a PSRAM device model and a byte-level reference memory
module tb_psram_apb_qpi_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        sck;
    logic        ce_n;
    logic [3:0]  dio_o;
    logic [3:0]  dio_oe;
    logic [3:0]  w_bus;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    psram_apb_qpi_ctrl dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_psel         (psel),
        .i_penable      (penable),
        .i_pwrite       (pwrite),
        .i_paddr        (paddr),
        .i_pwdata       (pwdata),
        .i_pstrb        (pstrb),
        .o_pready       (pready),
        .o_prdata       (prdata),
        .o_pslverr      (pslverr),
        .o_psram_sck    (sck),
        .o_psram_ce_n   (ce_n),
        .o_psram_dio_o  (dio_o),
        .o_psram_dio_oe (dio_oe),
        .i_psram_dio_i  (w_bus)
    );

    // ---------------- PSRAM device model ----------------
    bit [7:0]    dev_mem [logic [23:0]];
    logic        m_oe = 1'b0;
    logic [3:0]  m_drv = '0;
    int          m_cnt = 0;
    logic [7:0]  m_cmd = '0;
    logic [23:0] m_addr = '0;
    logic [3:0]  m_hi = '0;
    logic        m_prev = 1'b0;
    bit          contention = 0;

    // Resolved dio bus: device when it drives, else DUT lanes with oe, undriven lanes read 0.
    assign w_bus = m_oe ? m_drv : (dio_o & dio_oe);

    always @(negedge clk) begin
        if (ce_n) begin
            m_cnt = 0;
            m_oe  = 1'b0;
        end else if (sck && !m_prev) begin
            if (m_cnt < 8) m_cmd = {m_cmd[6:0], w_bus[0]};
            else if (m_cnt < 14) m_addr = {m_addr[19:0], w_bus};
            else if (m_cmd == 8'h38) begin
                if (((m_cnt - 14) % 2) == 0) m_hi = w_bus;
                else begin
                    dev_mem[m_addr] = {m_hi, w_bus};
                    m_addr = m_addr + 24'd1;
                end
            end
            m_cnt++;
        end else if (!sck && m_prev) begin
            if (m_cmd == 8'hEB && m_cnt >= 21 && m_cnt < 29) begin
                int j;
                logic [23:0] k;
                bit [7:0] b;
                j = m_cnt - 21;
                k = m_addr + 24'(j / 2);
                b = dev_mem.exists(k) ? dev_mem[k] : 8'h00;
                m_drv = ((j % 2) == 0) ? b[7:4] : b[3:0];
                m_oe  = 1'b1;
            end else begin
                m_oe = 1'b0;
            end
        end
        m_prev = sck;
        if (m_oe && dio_oe != 4'b0000) contention = 1;
    end

    // ---------------- reference model ----------------
    bit [7:0] ref_mem [logic [23:0]];

    function automatic bit strobe_ok(input logic [3:0] s);
        logic [4:0] t;
        if (s == 4'b0000) return 0;
        t = {1'b0, s};
        while (t[0] == 1'b0) t = t >> 1;
        return (t & (t + 5'd1)) == 5'd0;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            logic [23:0] k;
            k = {a[23:2], 2'(i)};
            w[8*i +: 8] = ref_mem.exists(k) ? ref_mem[k] : 8'h00;
        end
        return w;
    endfunction

    function automatic int ref_latency(input bit wr, input logic [3:0] s);
        if (!wr) return 2 * (8 + 6 + 7 + 8) + 3;
        if (!strobe_ok(s)) return 2;
        return 2 * (8 + 6 + 2 * $countones(s)) + 3;
    endfunction

    task automatic ref_apply(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (wr && strobe_ok(s))
            for (int i = 0; i < 4; i++)
                if (s[i]) ref_mem[{a[23:2], 2'(i)}] = d[8*i +: 8];
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic apb(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic err, output int lat,
                       output bit ce_low, output logic after);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(negedge clk);
        penable = 1'b1;
        lat = 0; ce_low = 0; rd = '0; err = 1'b0; after = 1'b0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (!ce_n) ce_low = 1;
            if (pready) break;
        end
        if (pready) begin
            rd  = prdata;
            err = pslverr;
            @(posedge clk); #1;
            after = pready;
        end else begin
            lat = -1;
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    task automatic run_vec(input string tag, input vec_t v);
        logic [31:0] rd;
        logic err, after;
        int lat;
        bit ce_low;
        apb(v.wr, v.addr, v.data, v.strb, rd, err, lat, ce_low, after);
        chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, " pslverr"}, 32'(err), 32'(v.exp_err));
        chk({tag, " pready pulse"}, 32'(after), 32'd0);
        if (!v.wr) chk({tag, " prdata"}, rd, v.exp_rd);
        if (v.exp_err) chk({tag, " ce_n stayed high"}, 32'(ce_low), 32'd0);
        ref_apply(v.wr, v.addr, v.data, v.strb);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h0,         1'b0, 47};
        vecs[1] = '{1'b0, 32'h0000_0100, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0, 61};
        vecs[2] = '{1'b1, 32'h0000_0200, 32'h0000_AB00, 4'b0010, 32'h0,         1'b0, 35};
        vecs[3] = '{1'b0, 32'h0000_0200, 32'h0,         4'b1111, 32'h0000_AB00, 1'b0, 61};
        vecs[4] = '{1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0101, 32'h0,         1'b1, 2};
        vecs[5] = '{1'b0, 32'h0000_0100, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0, 61};
        vecs[6] = '{1'b1, 32'h003F_FFFC, 32'hCAFE_F00D, 4'b1111, 32'h0,         1'b0, 47};
        vecs[7] = '{1'b0, 32'h003F_FFFC, 32'h0,         4'b0000, 32'hCAFE_F00D, 1'b0, 61};

        // Reset values, observed while reset is held
        repeat (3) @(posedge clk);
        #1;
        chk("reset ce_n", 32'(ce_n), 32'd1);
        chk("reset sck", 32'(sck), 32'd0);
        chk("reset oe", 32'(dio_oe), 32'd0);
        chk("reset dio_o", 32'(dio_o), 32'd0);
        chk("reset pready/pslverr", {30'd0, pready, pslverr}, 32'd0);
        chk("reset prdata", prdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset asserted mid-cycle during the ADDR phase of a read
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h100; pstrb = 4'h0;
        @(negedge clk);
        penable = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        chk("midreset ce_n low before", 32'(ce_n), 32'd0);
        chk("midreset oe in addr", 32'(dio_oe), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset ce_n", 32'(ce_n), 32'd1);
        chk("midreset sck", 32'(sck), 32'd0);
        chk("midreset oe", 32'(dio_oe), 32'd0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midreset pready", 32'(pready), 32'd0);
        repeat (3) @(posedge clk);
        run_vec("after reset read", '{1'b0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 61});

        // Randomized traffic against the reference memory
        for (int i = 0; i < 30; i++) begin
            vec_t v;
            v.wr      = 1'($urandom_range(0, 1));
            v.addr    = 32'h0000_0400 + 32'($urandom_range(0, 7)) * 4;
            v.data    = $urandom;
            v.strb    = 4'($urandom_range(0, 15));
            v.exp_rd  = ref_word(v.addr);
            v.exp_err = v.wr && !strobe_ok(v.strb);
            v.exp_lat = ref_latency(v.wr, v.strb);
            run_vec($sformatf("rand%0d", i), v);
        end

        chk("no dio contention", 32'(contention), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
